// File: rtl/skid_reg_pkg.sv
// Shared types for the skid_reg elastic pipeline register.
// State encoding doubles as the occupancy count.
package skid_reg_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    function automatic logic [OCC_W-1:0] occ_of(input skid_state_t s);
        logic [OCC_W-1:0] occ;
        case (s)
            EMPTY:   occ = 2'd0;
            HALF:    occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/reg_n.sv
// Purpose: WIDTH-bit load-enable register with synchronous clear.
// Latency: d appears on q one cycle after a load; clr wins over en.
// Backpressure: none, the caller decides when to load.
module reg_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/skid_reg.sv
// Purpose: 2-entry elastic pipeline register (main + skid), optional parity via SKID_REG_PARITY_EN.
// Latency: 1 cycle from accept to out_valid; full throughput of 1 word/cycle.
// Backpressure: in_ready depends only on state and en, so it drops only when both entries hold data.
module skid_reg
    import skid_reg_pkg::*;
#(
    parameter int WIDTH    = 65,
    parameter int CLR_DATA = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
`ifdef SKID_REG_PARITY_EN
    output logic             par_err,
`endif
    output logic [OCC_W-1:0] occupancy
);

`ifdef SKID_REG_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    skid_state_t state_q;
    skid_state_t state_d;

    logic          push;
    logic          pop;
    logic          main_ld;
    logic          skid_ld;
    logic          main_from_skid;
    logic          data_clr;
    logic [EW-1:0] in_entry;
    logic [EW-1:0] main_d;
    logic [EW-1:0] main_q;
    logic [EW-1:0] skid_q;

`ifdef SKID_REG_PARITY_EN
    assign in_entry = {^in_data, in_data};
`else
    assign in_entry = in_data;
`endif

    assign in_ready  = en & (state_q != FULL);
    assign out_valid = en & (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign occupancy = occ_of(state_q);
    assign out_data  = main_q[WIDTH-1:0];
    assign data_clr  = clr & (CLR_DATA != 0);

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = HALF;
                    main_ld = 1'b1;
                end
            end
            HALF: begin
                if (push && !pop) begin
                    state_d = FULL;
                    skid_ld = 1'b1;
                end else if (push && pop) begin
                    main_ld = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can move state.
                if (pop) begin
                    state_d        = HALF;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign main_d = main_from_skid ? skid_q : in_entry;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= EMPTY;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    reg_n #(.WIDTH(EW)) u_main (
        .clk (clk),
        .clr (data_clr),
        .en  (main_ld & ~clr),
        .d   (main_d),
        .q   (main_q)
    );

    reg_n #(.WIDTH(EW)) u_skid (
        .clk (clk),
        .clr (data_clr),
        .en  (skid_ld & ~clr),
        .d   (in_entry),
        .q   (skid_q)
    );

`ifdef SKID_REG_PARITY_EN
    logic par_err_q;
    logic par_err_d;

    always_comb begin
        par_err_d = par_err_q;
        if (pop && ((^main_q[WIDTH-1:0]) != main_q[WIDTH])) begin
            par_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            par_err_q <= 1'b0;
        end else if (en) begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

    a_occ_legal: assert property (@(posedge clk) disable iff (clr) occupancy != 2'd3);

endmodule
